// File: rtl/exu_div_issue_mbpta_ctl.sv
// Issue/collect controller for the constant-latency (MBPTA) divider: one request in flight, flush-safe.
// Optional latency checking and lat_err port are enabled by defining RV_DIV_MBPTA_LATENCY_CHECK_EN.
package exu_div_pkg;
    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } div_pkt_t;
endpackage

module exu_div_issue_mbpta_ctl
    import exu_div_pkg::*;
#(
    parameter int DIV_LATENCY = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_dividend,
    input  logic [31:0] req_divisor,
    input  logic        req_unsign,
    input  logic        req_rem,
    input  logic [4:0]  req_tag,
    input  logic        flush_lower,
    output div_pkt_t    dp,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic        div_stall,
    input  logic        div_finish,
    input  logic [31:0] div_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_tag,
    output logic [31:0] wb_data,
    output logic        busy
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
    ,
    output logic        lat_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        DRAIN
    } state_t;

    state_t     state;
    logic [5:0] cnt;

`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
    localparam logic [5:0] CNT_EXPECTED = 6'(DIV_LATENCY - 1);
    localparam logic [5:0] CNT_TIMEOUT  = 6'(DIV_LATENCY + 2);
`endif

    assign req_ready = (state == IDLE);

    // dp is a one-cycle launch pulse; every path except IDLE->ISSUE clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dp       <= '0;
            dividend <= '0;
            divisor  <= '0;
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_data  <= '0;
            busy     <= 1'b0;
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
            lat_err  <= 1'b0;
`endif
        end else begin
            dp <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && !flush_lower) begin
                        dividend  <= req_dividend;
                        divisor   <= req_divisor;
                        wb_tag    <= req_tag;
                        dp.valid  <= 1'b1;
                        dp.unsign <= req_unsign;
                        dp.rem    <= req_rem;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
                    if (div_finish) begin
                        lat_err <= 1'b1;
                    end
`endif
                end
                ISSUE: begin
                    cnt   <= 6'd1;
                    state <= flush_lower ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (cnt != 6'd63) begin
                        cnt <= cnt + 6'd1;
                    end
                    if (flush_lower && div_finish) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (div_finish) begin
                        wb_data  <= div_out;
                        wb_valid <= 1'b1;
                        state    <= WB;
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
                        if (cnt != CNT_EXPECTED) begin
                            lat_err <= 1'b1;
                        end
`endif
                    end else if (flush_lower) begin
                        state <= DRAIN;
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
                    end else if (cnt == CNT_TIMEOUT) begin
                        // Divider overdue: give up and treat any late completion as orphaned.
                        cnt     <= cnt;
                        lat_err <= 1'b1;
                        state   <= DRAIN;
`endif
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
                    if (div_finish) begin
                        lat_err <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (div_finish || !div_stall) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exu_div_issue_mbpta_ctl.sv
// Directed bench for exu_div_issue_mbpta_ctl with a fixed-latency divider model.
// Latency-check vectors are compiled in only when RV_DIV_MBPTA_LATENCY_CHECK_EN is defined.
module tb_exu_div_issue_mbpta_ctl;
    import exu_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        req_unsign;
    logic        req_rem;
    logic [4:0]  req_tag;
    logic        flush_lower;
    div_pkt_t    dp;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_stall;
    logic        div_finish;
    logic [31:0] div_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_tag;
    logic [31:0] wb_data;
    logic        busy;
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
    logic        lat_err;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    exu_div_issue_mbpta_ctl #(.DIV_LATENCY(36)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_unsign   (req_unsign),
        .req_rem      (req_rem),
        .req_tag      (req_tag),
        .flush_lower  (flush_lower),
        .dp           (dp),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_stall    (div_stall),
        .div_finish   (div_finish),
        .div_out      (div_out),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .busy         (busy)
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
        ,
        .lat_err      (lat_err)
`endif
    );

    // Divider model: finishes model_delay cycles after the request cycle, never reset by rst.
    int          mcnt = 0;
    logic        mact = 1'b0;
    int          model_delay;
    logic [31:0] model_result;
    logic        stall_kill;

    always @(posedge clk) begin
        if (dp.valid) begin
            mact <= 1'b1;
            mcnt <= 1;
        end else if (mact) begin
            if (div_finish) mact <= 1'b0;
            else mcnt <= mcnt + 1;
        end
    end

    assign div_finish = mact && (mcnt == model_delay - 1);
    assign div_stall  = mact && !stall_kill;
    assign div_out    = model_result;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Presents one request for a single cycle (cycle T); returns in cycle T+1.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic u,
                                 input logic r, input logic [4:0] t, input logic fl);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_unsign   = u;
        req_rem      = r;
        req_tag      = t;
        flush_lower  = fl;
        tick();
        req_valid   = 1'b0;
        flush_lower = 1'b0;
    endtask

    initial begin
        logic seen;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        req_unsign   = 1'b0;
        req_rem      = 1'b0;
        req_tag      = '0;
        flush_lower  = 1'b0;
        wb_ready     = 1'b1;
        model_delay  = 36;
        model_result = '0;
        stall_kill   = 1'b0;
        tick();
        tick();
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_dp", {29'b0, dp}, 32'd0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_wb_tag", {27'b0, wb_tag}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_operands", dividend | divisor, 32'd0);
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
        checkOutput("rst_lat_err", {31'b0, lat_err}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        $display("[TB] basic divide 100/7");
        model_result = 32'd14;
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 5'd5, 1'b0);
        checkOutput("basic_dp", {29'b0, dp}, 32'b100);
        checkOutput("basic_dividend", dividend, 32'd100);
        checkOutput("basic_divisor", divisor, 32'd7);
        checkOutput("basic_ready_low", {31'b0, req_ready}, 32'd0);
        checkOutput("basic_busy", {31'b0, busy}, 32'd1);
        tick();
        checkOutput("basic_dp_pulse", {31'b0, dp.valid}, 32'd0);
        repeat (33) tick();
        checkOutput("basic_wb_early", {31'b0, wb_valid}, 32'd0);
        tick();
        tick();
        checkOutput("basic_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("basic_wb_data", wb_data, 32'd14);
        checkOutput("basic_wb_tag", {27'b0, wb_tag}, 32'd5);
        tick();
        checkOutput("basic_ready_after", {31'b0, req_ready}, 32'd1);
        checkOutput("basic_wb_drop", {31'b0, wb_valid}, 32'd0);
        checkOutput("basic_idle", {31'b0, busy}, 32'd0);

        $display("[TB] writeback backpressure");
        wb_ready     = 1'b0;
        model_result = 32'd2;
        applyStimulus(32'd100, 32'd7, 1'b1, 1'b1, 5'd9, 1'b0);
        checkOutput("bp_dp", {29'b0, dp}, 32'b111);
        repeat (36) tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("bp_wb_valid", {31'b0, wb_valid}, 32'd1);
            checkOutput("bp_wb_data", wb_data, 32'd2);
            checkOutput("bp_wb_tag", {27'b0, wb_tag}, 32'd9);
            checkOutput("bp_ready_low", {31'b0, req_ready}, 32'd0);
            if (i == 3) wb_ready = 1'b1;
            tick();
        end
        checkOutput("bp_ready_after", {31'b0, req_ready}, 32'd1);
        checkOutput("bp_wb_drop", {31'b0, wb_valid}, 32'd0);

        $display("[TB] flush in WAIT");
        model_result = 32'd77;
        applyStimulus(32'd50, 32'd5, 1'b0, 1'b0, 5'd3, 1'b0);
        repeat (9) tick();
        flush_lower = 1'b1;
        tick();
        flush_lower = 1'b0;
        checkOutput("fl_busy", {31'b0, busy}, 32'd1);
        seen = 1'b0;
        for (int i = 11; i < 36; i++) begin
            seen |= wb_valid;
            tick();
        end
        checkOutput("fl_drain_ready", {31'b0, req_ready}, 32'd0);
        seen |= wb_valid;
        tick();
        checkOutput("fl_ready_after", {31'b0, req_ready}, 32'd1);
        checkOutput("fl_no_wb", {31'b0, seen | wb_valid}, 32'd0);

        $display("[TB] request with simultaneous flush");
        applyStimulus(32'd8, 32'd2, 1'b0, 1'b0, 5'd1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= dp.valid | busy;
            tick();
        end
        checkOutput("sf_no_issue", {31'b0, seen}, 32'd0);
        checkOutput("sf_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("sf_operands_kept", dividend, 32'd50);

        $display("[TB] early completion");
        model_delay  = 30;
        model_result = 32'd123;
        applyStimulus(32'd9, 32'd3, 1'b0, 1'b0, 5'd7, 1'b0);
        repeat (29) tick();
        checkOutput("early_wb_before", {31'b0, wb_valid}, 32'd0);
        tick();
        checkOutput("early_wb_valid", {31'b0, wb_valid}, 32'd1);
        checkOutput("early_wb_data", wb_data, 32'd123);
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
        checkOutput("early_lat_err", {31'b0, lat_err}, 32'd1);
`endif
        tick();
        checkOutput("early_ready_after", {31'b0, req_ready}, 32'd1);
        tick();
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
        checkOutput("early_lat_err_sticky", {31'b0, lat_err}, 32'd1);

        $display("[TB] divider timeout");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("to_lat_err_clear", {31'b0, lat_err}, 32'd0);
        model_delay = 100000;
        applyStimulus(32'd1, 32'd1, 1'b0, 1'b0, 5'd2, 1'b0);
        repeat (38) tick();
        checkOutput("to_still_wait", {31'b0, lat_err}, 32'd0);
        tick();
        checkOutput("to_lat_err", {31'b0, lat_err}, 32'd1);
        checkOutput("to_busy", {31'b0, busy}, 32'd1);
        stall_kill = 1'b1;
        tick();
        checkOutput("to_drain_exit", {31'b0, req_ready}, 32'd1);
        checkOutput("to_no_wb", {31'b0, wb_valid}, 32'd0);
        stall_kill = 1'b0;
`endif

        $display("[TB] reset during WAIT");
        model_delay  = 36;
        model_result = 32'd55;
        applyStimulus(32'd20, 32'd4, 1'b0, 1'b0, 5'd4, 1'b0);
        repeat (19) tick();
        rst = 1'b1;
        #1;
        checkOutput("mr_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("mr_dp", {29'b0, dp}, 32'd0);
        checkOutput("mr_busy", {31'b0, busy}, 32'd0);
        checkOutput("mr_wb_tag", {27'b0, wb_tag}, 32'd0);
        checkOutput("mr_wb_data", wb_data, 32'd0);
        checkOutput("mr_operands", dividend | divisor, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 21; i < 41; i++) begin
            seen |= wb_valid | busy;
            tick();
        end
        checkOutput("mr_stray_ignored", {31'b0, seen}, 32'd0);
`ifdef RV_DIV_MBPTA_LATENCY_CHECK_EN
        checkOutput("mr_stray_lat_err", {31'b0, lat_err}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/exu_div_issue_mbpta_ctl.md
# exu_div_issue_mbpta_ctl

Initiator side of the constant-latency (MBPTA) divide interface. It accepts one divide request from decode, launches it to the fixed-latency divider with a single-cycle `dp.valid`, ignores stale completions after a flush, captures the quotient or remainder on `finish`, and holds it on a valid/ready writeback port. It sits in the EXU between decode and the MBPTA divider wrapper, and checks that every completion arrives at exactly the configured latency.

## Interface
Parameters:
- `DIV_LATENCY`, default 36: divider latency in cycles. Must match the divider wrapper. Legal range is 2..61.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: divide request from decode.
- `req_ready` out 1: block can accept a request.
- `req_dividend` in 32: numerator.
- `req_divisor` in 32: denominator.
- `req_unsign` in 1: unsigned divide.
- `req_rem` in 1: return the remainder instead of the quotient.
- `req_tag` in 5: destination register index.
- `flush_lower` in 1: pipeline flush.
- `dp` out div_pkt_t: `valid`/`unsign`/`rem` to the divider.
- `dividend` out 32: operand to the divider.
- `divisor` out 32: operand to the divider.
- `div_stall` in 1: divider busy.
- `div_finish` in 1: divider completion.
- `div_out` in 32: divider result, valid while `div_finish` is high.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepted.
- `wb_tag` out 5: destination register index of the result.
- `wb_data` out 32: result.
- `busy` out 1: any state other than IDLE.
- `lat_err` out 1: sticky latency-violation flag. Only present with the macro; see Configuration.

## Operation
State machine: IDLE, ISSUE, WAIT, WB, DRAIN. Reset state is IDLE.
- **IDLE:** `req_ready`=1.
  - On `req_valid & req_ready & !flush_lower`, register the operands, `unsign`, `rem` and `tag`, then go to ISSUE.
  - A request arriving in the same cycle as `flush_lower` is dropped.
- **ISSUE** (one cycle):
  - Drive `dp.valid`=1; registered operands are on `dividend`/`divisor`.
  - Load the 6-bit cycle counter `cnt` with 1 and go to WAIT.
  - If `flush_lower`=1, go to DRAIN. The divider has already seen `dp.valid`.
- **WAIT:** `cnt` increments each cycle, saturating at 63.
  - On `div_finish`, capture `div_out` into `wb_data` and go to WB.
  - On `flush_lower` without `div_finish`, go to DRAIN.
  - If `flush_lower` and `div_finish` occur together, flush wins: no capture, go to IDLE.
- **WB:** `wb_valid`=1, with `wb_data`/`wb_tag` held stable.
  - On `wb_valid & wb_ready`, go to IDLE.
  - `flush_lower` is ignored here because the result has already been produced.
- **DRAIN:** wait for the orphaned completion.
  - On `div_finish`, or on `!div_stall` for one cycle, go to IDLE.
  - The result is discarded and `req_ready`=0.
- `dp.valid` is high only in ISSUE. `dp.unsign`/`dp.rem` are the registered values in ISSUE and 0 otherwise.
- `dividend`/`divisor` hold the last registered operands.
- `div_finish` seen in IDLE or WB is ignored, and flags an error if the macro is enabled.
- Reset mid-operation returns to IDLE immediately. Any in-flight divider result is then ignored as a stale finish.

## Timing
Reset values:
- `req_ready`=1; `dp`=0; `wb_valid`=0; `busy`=0; `lat_err`=0.
- `wb_tag`=0; `wb_data`=0; `dividend`=0; `divisor`=0; `cnt`=0.

Latencies:
- Request accepted at cycle T.
- `dp.valid` at T+1.
- Expected `div_finish` at T+DIV_LATENCY, i.e. DIV_LATENCY−1 cycles after the `dp.valid` cycle. At that cycle `cnt`==DIV_LATENCY−1.
- `wb_valid` rises at T+DIV_LATENCY+1.

Throughput:
- Writeback handshake at cycle W means `req_ready`=1 at W+1.
- Minimum spacing between accepted requests is DIV_LATENCY+2 cycles.

All outputs are registered, except that `req_ready` is decoded from the state register.

## Configuration
Macro `RV_DIV_MBPTA_LATENCY_CHECK_EN`.
- **Defined:** `lat_err` port exists. It is set and held until `rst` by any of:
  - `div_finish` in WAIT with `cnt`≠DIV_LATENCY−1;
  - `cnt` reaching DIV_LATENCY+2 in WAIT, which also forces a transition to DRAIN;
  - `div_finish` in IDLE or WB.
- **Undefined:** no `lat_err` port and no timeout. Any WAIT-state `div_finish` is accepted.

## Test plan
- **Basic divide:** reset, then request 100/7 signed with `rem`=0 and `tag`=5. Expect `dp.valid` at T+1, a divider model finishing at T+36 with `div_out`=14, and `wb_valid` at T+37 with `wb_data`=14 and `wb_tag`=5.
- **Writeback backpressure:** same request with `wb_ready` held low for 4 cycles. `wb_valid`, `wb_data` and `wb_tag` stay stable, and `req_ready`=1 only the cycle after the handshake.
- **Flush in WAIT:** flush at T+10. Go to DRAIN; the model's finish at T+36 is discarded; `wb_valid` is never asserted; `req_ready`=1 at T+37.
- **Simultaneous flush and request in IDLE:** request 8/2 with `flush_lower` asserted in the same cycle. `dp.valid` is never asserted.
- **Latency check, macro defined:** the model finishes at T+30. `lat_err`=1 from T+31 and stays high. With the model never finishing, `lat_err`=1 and the block reaches DRAIN when `cnt`=38.
- **Reset in WAIT:** assert `rst` at T+20. All outputs return to their reset values at once; a later stray `div_finish` produces no writeback.
